// File: rtl/tbird_pkg.sv
// Shared constants for the T-bird input conditioning stage: default timing,
// synchronizer depth and counter-width helper.
package tbird_pkg;

   localparam int TICK_DIV_DEF   = 12500000;
   localparam int DEB_CYCLES_DEF = 1000000;
   localparam int SYNC_DEPTH     = 2;

   localparam int TICK_W_DEF = $clog2(TICK_DIV_DEF);
   localparam int DEB_W_DEF  = $clog2(DEB_CYCLES_DEF);

   // Width of a counter spanning 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a consecutive-mismatch debounce counter.
// RST_VAL sets the idle level of both the synchronizer and the debounced output.
module sw_debounce
   import tbird_pkg::*;
#(
   parameter int   DEB_CYCLES = DEB_CYCLES_DEF,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic deb_o
);

   localparam int            CW      = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  sync_s;
   logic                  deb_q, deb_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   assign sync_s = sync_q[SYNC_DEPTH-1];
   assign deb_o  = deb_q;

   // Synchronizer shift register and debounce state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {SYNC_DEPTH{RST_VAL}};
         deb_q  <= RST_VAL;
         cnt_q  <= {CW{1'b0}};
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], raw_i};
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   // Any agreement restarts the count; the output flips only after a full run.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (sync_s == deb_q) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == CNT_MAX) begin
         deb_d = sync_s;
         cnt_d = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/tbird_input_ctrl.sv
// Conditions the raw DE2 switches/keys and produces the sequencer advance strobe
// plus left/right requests that only change on strobe cycles.
module tbird_input_ctrl
   import tbird_pkg::*;
#(
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic turn_sw,
   input  logic dir_sw,
   input  logic hazard_sw,
   input  logic manual_sw,
   input  logic step_key_n,
   output logic tick,
   output logic left_req,
   output logic right_req
);

   localparam int               DIV_W   = cnt_width(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

   logic turn_s, dir_s, hazard_s, manual_s, step_s;
   logic manual_chg_s, step_fall_s, l_s, r_s;

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             left_q, left_d;
   logic             right_q, right_d;
   logic             manual_prev_q, step_prev_q;

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_turn (
      .clk_i(clk), .rst_ni(reset), .raw_i(turn_sw), .deb_o(turn_s));
   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_dir (
      .clk_i(clk), .rst_ni(reset), .raw_i(dir_sw), .deb_o(dir_s));
   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_hazard (
      .clk_i(clk), .rst_ni(reset), .raw_i(hazard_sw), .deb_o(hazard_s));
   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_manual (
      .clk_i(clk), .rst_ni(reset), .raw_i(manual_sw), .deb_o(manual_s));
   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_step (
      .clk_i(clk), .rst_ni(reset), .raw_i(step_key_n), .deb_o(step_s));

   assign manual_chg_s = manual_s ^ manual_prev_q;
   assign step_fall_s  = step_prev_q & ~step_s;
   assign l_s          = hazard_s | (turn_s & ~dir_s);
   assign r_s          = hazard_s | (turn_s & dir_s);

   assign tick      = tick_q;
   assign left_req  = left_q;
   assign right_req = right_q;

   // Divider, strobe, request and edge-detect registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q         <= {DIV_W{1'b0}};
         tick_q        <= 1'b0;
         left_q        <= 1'b0;
         right_q       <= 1'b0;
         manual_prev_q <= 1'b0;
         step_prev_q   <= 1'b1;
      end else begin
         div_q         <= div_d;
         tick_q        <= tick_d;
         left_q        <= left_d;
         right_q       <= right_d;
         manual_prev_q <= manual_s;
         step_prev_q   <= step_s;
      end
   end

   // A mode change outranks both a divider wrap and a step press.
   always_comb begin
      div_d  = div_q;
      tick_d = 1'b0;
      if (manual_chg_s) begin
         div_d = {DIV_W{1'b0}};
      end else if (manual_s) begin
         div_d  = {DIV_W{1'b0}};
         tick_d = step_fall_s;
      end else if (div_q == DIV_MAX) begin
         div_d  = {DIV_W{1'b0}};
         tick_d = 1'b1;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
      left_d  = tick_d ? l_s : left_q;
      right_d = tick_d ? r_s : right_q;
   end

endmodule

// File: tb/tb_tbird_input_ctrl.sv
// Directed bench for tbird_input_ctrl with TICK_DIV=8 and DEB_CYCLES=4.
module tb_tbird_input_ctrl;

   logic clk = 1'b0;
   logic reset, turn_sw, dir_sw, hazard_sw, manual_sw, step_key_n;
   logic tick, left_req, right_req;
   int   checks = 0;
   int   errors = 0;
   logic tick_prev = 1'b0;

   tbird_input_ctrl #(.TICK_DIV(8), .DEB_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .turn_sw(turn_sw), .dir_sw(dir_sw),
      .hazard_sw(hazard_sw), .manual_sw(manual_sw), .step_key_n(step_key_n),
      .tick(tick), .left_req(left_req), .right_req(right_req));

   always #5 clk = ~clk;

   // Strobe must never be high on two consecutive cycles.
   always @(negedge clk) begin
      if (tick) begin
         checks++;
         if (tick_prev) begin
            errors++;
            $display("FAIL tick_consecutive at %0t: tick high two cycles in a row", $time);
         end
      end
      tick_prev <= tick;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (tick) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic check_outs(input string name, input logic t, input logic l, input logic r);
      checks++;
      if ({tick, left_req, right_req} !== {t, l, r}) begin
         errors++;
         $display("FAIL %s: tick/left/right got %b%b%b expected %b%b%b",
                  name, tick, left_req, right_req, t, l, r);
      end
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         {turn_sw, dir_sw, hazard_sw, manual_sw, step_key_n} = 5'(i * 7 + 3);
         step();
         check_outs("reset_hold", 1'b0, 1'b0, 1'b0);
      end
      {turn_sw, dir_sw, hazard_sw, manual_sw} = 4'b0000;
      step_key_n = 1'b1;
      step();
      reset = 1'b1;
      wait_tick(30, n);
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL reset_first_tick: got %0d cycles expected 8", n);
      end
      step();
      check_outs("tick_width", 1'b0, 1'b0, 1'b0);
      wait_tick(30, n);
      checks++;
      if (n !== 7) begin
         errors++;
         $display("FAIL tick_period: got %0d cycles expected 7 after low cycle", n);
      end
   endtask

   task automatic test_debounce();
      turn_sw = 1'b1;
      dir_sw  = 1'b1;
      repeat (7) step();
      check_outs("deb_before_tick", 1'b0, 1'b0, 1'b0);
      step();
      check_outs("deb_right_on_tick", 1'b1, 1'b0, 1'b1);
      turn_sw = 1'b0;
      repeat (3) step();
      turn_sw = 1'b1;
      repeat (5) step();
      check_outs("deb_glitch_ignored", 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_request_hold();
      dir_sw = 1'b0;
      step();
      check_outs("hold_after_change", 1'b0, 1'b0, 1'b1);
      repeat (6) step();
      check_outs("hold_before_tick", 1'b0, 1'b0, 1'b1);
      step();
      check_outs("hold_left_on_tick", 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_hazard();
      hazard_sw = 1'b1;
      turn_sw   = 1'b0;
      repeat (7) step();
      check_outs("hazard_before_tick", 1'b0, 1'b1, 1'b0);
      step();
      check_outs("hazard_on_tick", 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_manual();
      int cnt, first;
      manual_sw = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tick) cnt++;
      end
      checks++;
      if (cnt !== 0) begin
         errors++;
         $display("FAIL manual_no_auto: got %0d ticks expected 0", cnt);
      end
      step_key_n = 1'b0;
      cnt   = 0;
      first = -1;
      for (int i = 1; i <= 14; i++) begin
         step();
         if (i == 6) step_key_n = 1'b1;
         if (tick) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (cnt !== 1 || first !== 7) begin
         errors++;
         $display("FAIL manual_press: got %0d ticks first at %0d expected 1 at 7", cnt, first);
      end
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (tick) cnt++;
      end
      checks++;
      if (cnt !== 0) begin
         errors++;
         $display("FAIL manual_release: got %0d ticks expected 0", cnt);
      end
   endtask

   task automatic test_collision_reset();
      int n, cnt;
      manual_sw = 1'b0;
      wait_tick(40, n);
      checks++;
      if (n !== 15) begin
         errors++;
         $display("FAIL auto_resume: got %0d cycles expected 15", n);
      end
      check_outs("auto_resume_reqs", 1'b1, 1'b1, 1'b1);
      step();
      manual_sw = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (tick) cnt++;
      end
      checks++;
      if (cnt !== 0) begin
         errors++;
         $display("FAIL collision_no_tick: got %0d ticks expected 0", cnt);
      end
      manual_sw = 1'b0;
      wait_tick(40, n);
      checks++;
      if (n !== 15) begin
         errors++;
         $display("FAIL collision_restart: got %0d cycles expected 15", n);
      end
      repeat (3) step();
      check_outs("pre_reset_reqs", 1'b0, 1'b1, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check_outs("async_reset", 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      check_outs("reset_held", 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      wait_tick(30, n);
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL post_reset_tick: got %0d cycles expected 8", n);
      end
      check_outs("post_reset_reqs", 1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      reset      = 1'b0;
      turn_sw    = 1'b0;
      dir_sw     = 1'b0;
      hazard_sw  = 1'b0;
      manual_sw  = 1'b0;
      step_key_n = 1'b1;
      test_reset();
      test_debounce();
      test_request_hold();
      test_hazard();
      test_manual();
      test_collision_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
